// File: rtl/gfx_cmd_dispatch.sv
// Graphics command-list dispatcher: parses header/argument words from a command
// stream and steers them to per-engine handshake channels.
module gfx_cmd_dispatch #(
  parameter int                     NUM_ENG  = 4,
  parameter int                     DATA_W   = 32,
  parameter int                     OP_LSB   = 24,
  parameter logic [7:0]             STOP_OP  = 8'h00,
  parameter logic [NUM_ENG*8-1:0]   ENG_OPS  = {8'h04, 8'h03, 8'h02, 8'h01},
  parameter logic [NUM_ENG*4-1:0]   ENG_ARGS = {4'd1, 4'd2, 4'd1, 4'd0}
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [31:0]        frame_in,
  input  logic               abort,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [DATA_W-1:0]  cmd_data,
  output logic [NUM_ENG-1:0] eng_valid,
  input  logic [NUM_ENG-1:0] eng_ready,
  output logic [DATA_W-1:0]  eng_data,
  output logic               eng_first,
  output logic               eng_last,
  output logic [31:0]        frame_out,
  output logic               busy,
  output logic               irq,
  output logic               err,
  output logic [7:0]         err_op,
  output logic [15:0]        cmd_count
);

  typedef enum logic [1:0] {IDLE, HEAD, ARGS} state_t;

  state_t      state_q, state_d;
  logic [31:0] frame_q, frame_d;
  logic        err_q, err_d;
  logic [7:0]  err_op_q, err_op_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  rem_q, rem_d;
  logic [2:0]  sel_q, sel_d;

  logic [7:0]  op;
  logic        hit;
  logic [2:0]  hit_k;
  logic [3:0]  hit_args;
  logic        xfer;

  assign op = cmd_data[OP_LSB +: 8];

  // Scan from the top so the lowest matching channel is the one that sticks.
  always_comb begin
    hit      = 1'b0;
    hit_k    = 3'd0;
    hit_args = 4'd0;
    for (int k = NUM_ENG - 1; k >= 0; k--) begin
      if (op == ENG_OPS[8*k +: 8]) begin
        hit      = 1'b1;
        hit_k    = 3'(k);
        hit_args = ENG_ARGS[4*k +: 4];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    frame_d   = frame_q;
    err_d     = err_q;
    err_op_d  = err_op_q;
    cnt_d     = cnt_q;
    rem_d     = rem_q;
    sel_d     = sel_q;
    cmd_ready = 1'b0;
    eng_valid = '0;
    eng_first = 1'b0;
    eng_last  = 1'b0;
    irq       = 1'b0;
    xfer      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = HEAD;
          frame_d  = frame_in;
          err_d    = 1'b0;
          err_op_d = 8'h00;
          cnt_d    = 16'h0000;
        end
      end
      HEAD: begin
        if (op == STOP_OP) begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            irq     = 1'b1;
            state_d = IDLE;
          end
        end else if (hit) begin
          for (int k = 0; k < NUM_ENG; k++) begin
            if (hit_k == 3'(k)) begin
              eng_valid[k] = cmd_valid;
              cmd_ready    = eng_ready[k];
            end
          end
          eng_first = 1'b1;
          eng_last  = (hit_args == 4'd0);
          xfer      = cmd_valid & cmd_ready;
          if (xfer) begin
            cnt_d = cnt_q + 16'd1;
            if (hit_args != 4'd0) begin
              rem_d   = hit_args;
              sel_d   = hit_k;
              state_d = ARGS;
            end
          end
        end else begin
          cmd_ready = 1'b1;
          if (cmd_valid) begin
            err_d = 1'b1;
            if (!err_q) err_op_d = op;
          end
        end
      end
      ARGS: begin
        for (int k = 0; k < NUM_ENG; k++) begin
          if (sel_q == 3'(k)) begin
            eng_valid[k] = cmd_valid;
            cmd_ready    = eng_ready[k];
          end
        end
        eng_last = (rem_q == 4'd1);
        xfer     = cmd_valid & cmd_ready;
        if (xfer) begin
          rem_d = rem_q - 4'd1;
          if (rem_q == 4'd1) state_d = HEAD;
        end
      end
      default: state_d = IDLE;
    endcase

    // Abort and reset both suppress any handshake in this cycle.
    if (abort || !rst_n) begin
      cmd_ready = 1'b0;
      eng_valid = '0;
      eng_first = 1'b0;
      eng_last  = 1'b0;
      irq       = 1'b0;
    end
    if (abort) begin
      state_d  = IDLE;
      rem_d    = 4'd0;
      frame_d  = frame_q;
      err_d    = err_q;
      err_op_d = err_op_q;
      cnt_d    = cnt_q;
      sel_d    = sel_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      frame_q  <= 32'h0;
      err_q    <= 1'b0;
      err_op_q <= 8'h00;
      cnt_q    <= 16'h0000;
      rem_q    <= 4'd0;
      sel_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      frame_q  <= frame_d;
      err_q    <= err_d;
      err_op_q <= err_op_d;
      cnt_q    <= cnt_d;
      rem_q    <= rem_d;
      sel_q    <= sel_d;
    end
  end

  assign eng_data  = cmd_data;
  assign frame_out = frame_q;
  assign busy      = (state_q != IDLE);
  assign err       = err_q;
  assign err_op    = err_op_q;
  assign cmd_count = cnt_q;

endmodule

// File: tb/tb_gfx_cmd_dispatch.sv
// Scoreboard bench for gfx_cmd_dispatch: directed command lists, engine-side
// transfers checked by an independent monitor against queued expectations.
module tb_gfx_cmd_dispatch;

  logic        clk = 1'b0;
  logic        rst_n, start, abort, cmd_valid;
  logic        cmd_ready;
  logic [31:0] frame_in, cmd_data;
  logic [3:0]  eng_valid, eng_ready;
  logic [31:0] eng_data, frame_out;
  logic        eng_first, eng_last, busy, irq, err;
  logic [7:0]  err_op;
  logic [15:0] cmd_count;

  always #5 clk = ~clk;

  // Channel 1 carries two args, channel 2 and 3 one, channel 0 none.
  gfx_cmd_dispatch #(
    .ENG_ARGS({4'd1, 4'd1, 4'd2, 4'd0})
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .frame_in(frame_in), .abort(abort),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
    .eng_valid(eng_valid), .eng_ready(eng_ready), .eng_data(eng_data),
    .eng_first(eng_first), .eng_last(eng_last), .frame_out(frame_out),
    .busy(busy), .irq(irq), .err(err), .err_op(err_op), .cmd_count(cmd_count)
  );

  typedef struct {
    int          ch;
    logic [31:0] d;
    logic        f;
    logic        l;
  } exp_t;

  exp_t sb_q[$];
  int   n_total = 0;
  int   n_pass  = 0;
  int   irq_cnt = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, expv);
  endtask

  task automatic expect_word(input int ch, input logic [31:0] d, input logic f, input logic l);
    exp_t e;
    e.ch = ch; e.d = d; e.f = f; e.l = l;
    sb_q.push_back(e);
  endtask

  // Monitor: a transfer is visible at the negedge before the edge that completes it.
  always @(negedge clk) begin
    if (irq) irq_cnt++;
    for (int k = 0; k < 4; k++) begin
      if (eng_valid[k] && eng_ready[k]) begin
        chk("eng_onehot", 64'($countones(eng_valid)), 64'd1);
        if (sb_q.size() == 0) begin
          chk("eng_unexpected", {32'(k), eng_data}, 64'hFFFFFFFF_FFFFFFFF);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          chk("eng_xfer", {28'(k), eng_data, eng_first, eng_last, 2'b00},
                          {28'(e.ch), e.d, e.f, e.l, 2'b00});
        end
      end
    end
  end

  task automatic start_list(input logic [31:0] f);
    start = 1'b1; frame_in = f;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Present one word, optionally starving the engines first, and wait for its handshake.
  task automatic send(input logic [31:0] w, input int stall);
    int n;
    cmd_valid = 1'b1; cmd_data = w;
    if (stall > 0) begin
      eng_ready = 4'h0;
      repeat (stall) begin @(posedge clk); #1; end
    end
    eng_ready = 4'hF;
    n = 0;
    forever begin
      @(negedge clk);
      if (cmd_ready) break;
      n++;
      if (n > 50) begin
        chk("send_timeout", 64'(w), 64'hDEAD);
        cmd_valid = 1'b0;
        return;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  initial begin
    int irq0;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; cmd_valid = 1'b0;
    frame_in = 32'h0; cmd_data = 32'h0; eng_ready = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd0);
    chk("rst_eng_valid", 64'(eng_valid), 64'd0);
    chk("rst_state_regs", {err, err_op, cmd_count, frame_out}, 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Single zero-arg command then STOP.
    start_list(32'h10400000);
    chk("busy_after_start", 64'(busy), 64'd1);
    start_list(32'h55555555);
    chk("start_while_busy", 64'(frame_out), 64'h10400000);
    irq0 = irq_cnt;
    expect_word(0, 32'h01FF0000, 1'b1, 1'b1);
    send(32'h01FF0000, 0);
    send(32'h00000000, 0);
    chk("irq_single", 64'(irq_cnt - irq0), 64'd1);
    chk("frame_out", 64'(frame_out), 64'h10400000);
    chk("count_one", 64'(cmd_count), 64'd1);
    chk("idle_after_stop", 64'(busy), 64'd0);

    // Two-arg command under engine backpressure.
    start_list(32'h20000000);
    expect_word(1, 32'h02000000, 1'b1, 1'b0);
    expect_word(1, 32'h00100020, 1'b0, 1'b0);
    expect_word(1, 32'h00300040, 1'b0, 1'b1);
    send(32'h02000000, 3);
    send(32'h00100020, 3);
    send(32'h00300040, 3);
    chk("bp_drained", 64'(sb_q.size()), 64'd0);
    send(32'h00000000, 0);

    // Unknown opcodes then a valid one-arg command.
    start_list(32'h30000000);
    send(32'h7E000000, 0);
    send(32'h7F123456, 0);
    expect_word(2, 32'h03000001, 1'b1, 1'b0);
    expect_word(2, 32'hCAFEF00D, 1'b0, 1'b1);
    send(32'h03000001, 0);
    send(32'hCAFEF00D, 0);
    chk("err", 64'(err), 64'd1);
    chk("err_op", 64'(err_op), 64'h7E);
    chk("count_after_err", 64'(cmd_count), 64'd1);
    send(32'h00000000, 0);

    // Abort mid-command, then a clean list.
    start_list(32'h40000000);
    irq0 = irq_cnt;
    expect_word(1, 32'h02000000, 1'b1, 1'b0);
    expect_word(1, 32'h00100020, 1'b0, 1'b0);
    send(32'h02000000, 0);
    send(32'h00100020, 0);
    abort = 1'b1; start = 1'b1; frame_in = 32'hBAD0BAD0;
    @(posedge clk); #1;
    abort = 1'b0; start = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_frame", 64'(frame_out), 64'h40000000);
    chk("abort_no_irq", 64'(irq_cnt - irq0), 64'd0);
    start_list(32'h41000000);
    expect_word(0, 32'h01AA0000, 1'b1, 1'b1);
    send(32'h01AA0000, 0);
    send(32'h00000000, 0);
    chk("post_abort_irq", 64'(irq_cnt - irq0), 64'd1);
    chk("post_abort_count", 64'(cmd_count), 64'd1);

    // Reset while channel 3 waits for its argument.
    start_list(32'h50000000);
    expect_word(3, 32'h04000000, 1'b1, 1'b0);
    send(32'h04000000, 0);
    chk("ch3_in_args", 64'(busy), 64'd1);
    rst_n = 1'b0; cmd_valid = 1'b1; cmd_data = 32'h0BADBEEF; eng_ready = 4'hF;
    @(posedge clk); #1;
    rst_n = 1'b1; cmd_valid = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_ready", 64'({cmd_ready, eng_valid}), 64'd0);
    chk("midrst_regs", {err, err_op, cmd_count, frame_out}, 64'd0);

    // Counter wrap with back-to-back zero-arg commands.
    start_list(32'h60000000);
    cmd_valid = 1'b1; cmd_data = 32'h01000000;
    for (int i = 0; i < 65535; i++) begin
      expect_word(0, 32'h01000000, 1'b1, 1'b1);
      @(posedge clk); #1;
    end
    chk("count_ffff", 64'(cmd_count), 64'hFFFF);
    expect_word(0, 32'h01000000, 1'b1, 1'b1);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    chk("count_wrap", 64'(cmd_count), 64'd0);
    send(32'h00000000, 0);

    @(posedge clk); #1;
    chk("sb_empty", 64'(sb_q.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
